// File: rtl/partition_meter_pkg.sv
// Shared types and width helpers for the partition error meter.
// Optional feature macro used by the design: ERR_HAMMING_EN (Hamming-distance accumulator).
package partition_meter_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } meter_state_t;

    // err_cnt must hold 2^ni, the count when every vector differs
    function automatic int acc_cnt_width(input int ni);
        return ni + 1;
    endfunction

    // Sums of up to 2^ni terms, each below 2^no, fit in no+ni bits
    function automatic int acc_sum_width(input int ni, input int no);
        return ni + no;
    endfunction

    // Wait-counter width able to hold the value settle (at least one bit)
    function automatic int wait_width(input int settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/err_diff_unit.sv
// Combinational difference unit: unsigned |a-b| and, with ERR_HAMMING_EN,
// the number of differing bits between a and b.
module err_diff_unit
    import partition_meter_pkg::*;
#(
    parameter int NO = 4,
    parameter int PW = $clog2(NO + 1)
) (
    input  logic [NO-1:0] a,
    input  logic [NO-1:0] b,
`ifdef ERR_HAMMING_EN
    output logic [PW-1:0] popcnt,
`endif
    output logic [NO-1:0] diff
);

    // Absolute difference; subtract the smaller from the larger so no sign bit is needed
    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
    end

`ifdef ERR_HAMMING_EN
    logic [NO-1:0] xor_bits;

    // Per-bit disagreement between the two outputs
    generate
        for (genvar gi = 0; gi < NO; gi++) begin : g_xor
            assign xor_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // Population count of the disagreeing bits
    always_comb begin
        popcnt = '0;
        for (int i = 0; i < NO; i++) begin
            popcnt = popcnt + PW'(xor_bits[i]);
        end
    end
`endif

endmodule

// File: rtl/partition_error_meter.sv
// Exhaustive sweep of a partition pair: drives pi = 0..2^NI-1, holds each
// pattern SETTLE cycles, samples both outputs and accumulates error metrics.
// Optional feature macro: ERR_HAMMING_EN enables the hd_sum accumulator;
// when undefined hd_sum is constant zero.
module partition_error_meter
    import partition_meter_pkg::*;
#(
    parameter int NI     = 7,
    parameter int NO     = 4,
    parameter int SETTLE = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic [NI-1:0]                        pi,
    input  logic [NO-1:0]                        po_exact,
    input  logic [NO-1:0]                        po_approx,
    output logic                                 busy,
    output logic                                 done,
    output logic [acc_cnt_width(NI)-1:0]         err_cnt,
    output logic [acc_sum_width(NI, NO)-1:0]     err_sum,
    output logic [NO-1:0]                        err_max,
    output logic [acc_sum_width(NI, NO)-1:0]     hd_sum
);

    localparam int CW = acc_cnt_width(NI);
    localparam int SW = acc_sum_width(NI, NO);
    localparam int WW = wait_width(SETTLE);
    localparam int PW = $clog2(NO + 1);

    meter_state_t  state_reg, state_next;
    logic [NI-1:0] pi_reg, pi_next;
    logic [WW-1:0] wait_reg, wait_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [CW-1:0] err_cnt_reg, err_cnt_next;
    logic [SW-1:0] err_sum_reg, err_sum_next;
    logic [NO-1:0] err_max_reg, err_max_next;
    logic [NO-1:0] diff;

`ifdef ERR_HAMMING_EN
    logic [PW-1:0] popcnt;
    logic [SW-1:0] hd_sum_reg, hd_sum_next;
`endif

    err_diff_unit #(
        .NO (NO),
        .PW (PW)
    ) u_diff (
        .a      (po_exact),
        .b      (po_approx),
`ifdef ERR_HAMMING_EN
        .popcnt (popcnt),
`endif
        .diff   (diff)
    );

    // State and accumulator registers; reset returns everything to idle/zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pi_reg      <= '0;
            wait_reg    <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_cnt_reg <= '0;
            err_sum_reg <= '0;
            err_max_reg <= '0;
`ifdef ERR_HAMMING_EN
            hd_sum_reg  <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            pi_reg      <= pi_next;
            wait_reg    <= wait_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_cnt_reg <= err_cnt_next;
            err_sum_reg <= err_sum_next;
            err_max_reg <= err_max_next;
`ifdef ERR_HAMMING_EN
            hd_sum_reg  <= hd_sum_next;
`endif
        end
    end

    // Next-state logic: start only honoured when idle or finished
    always_comb begin
        state_next   = state_reg;
        pi_next      = pi_reg;
        wait_next    = wait_reg;
        busy_next    = busy_reg;
        done_next    = done_reg;
        err_cnt_next = err_cnt_reg;
        err_sum_next = err_sum_reg;
        err_max_next = err_max_reg;
`ifdef ERR_HAMMING_EN
        hd_sum_next  = hd_sum_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next   = ST_WAIT;
                    pi_next      = '0;
                    wait_next    = WW'(SETTLE);
                    busy_next    = 1'b1;
                    done_next    = 1'b0;
                    err_cnt_next = '0;
                    err_sum_next = '0;
                    err_max_next = '0;
`ifdef ERR_HAMMING_EN
                    hd_sum_next  = '0;
`endif
                end
            end
            ST_WAIT: begin
                // Counter was loaded with SETTLE; leaving at 1 gives SETTLE wait cycles
                if (wait_reg == WW'(1)) begin
                    state_next = ST_SAMPLE;
                end else begin
                    wait_next = wait_reg - WW'(1);
                end
            end
            ST_SAMPLE: begin
                err_cnt_next = err_cnt_reg + CW'(diff != '0);
                err_sum_next = err_sum_reg + SW'(diff);
                if (diff > err_max_reg) begin
                    err_max_next = diff;
                end
`ifdef ERR_HAMMING_EN
                hd_sum_next  = hd_sum_reg + SW'(popcnt);
`endif
                if (pi_reg == '1) begin
                    state_next = ST_DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                    pi_next    = pi_reg + NI'(1);
                    wait_next  = WW'(SETTLE);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pi      = pi_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err_cnt = err_cnt_reg;
    assign err_sum = err_sum_reg;
    assign err_max = err_max_reg;
`ifdef ERR_HAMMING_EN
    assign hd_sum  = hd_sum_reg;
`else
    assign hd_sum  = '0;
`endif

endmodule
